// File: rtl/uart_rx_core_if.sv
// Receiver-side bundle: serial line in, received word and status out.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  rx,
        output data, valid, parity_err, frame_err, busy
    );

    modport slave (
        output rx,
        input  data, valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampled UART frame receiver with 3-sample majority vote per bit.
// state  | meaning
// IDLE   | line idle, looking for a low level on a tick
// START  | qualifying the start bit at its midpoint
// DATA   | shifting in DATA_BITS voted data bits
// PARITY | checking the optional parity bit
// STOP   | sampling STOP_BITS stop bits, publishing the word
// BREAK  | line held low after a framing error, waiting for high
module uart_rx_core #(
    parameter int DIV        = 4,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_core_if.master bus
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q;
    logic [DIV_W-1:0]     div_cnt_q;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [1:0]           vote_q, vote_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_flag_q, par_flag_d;
    logic                 frm_flag_q, frm_flag_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 valid_q, valid_d;

    logic rxs;
    logic tick;
    logic bit_val;
    logic par_xor;
    logic frm_now;

    assign rxs     = sync_q[1];
    assign tick    = (div_cnt_q == DIV_LAST);
    // vote_q holds the samples from the two ticks before the decision tick
    assign bit_val = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxs) | (vote_q[0] & rxs);
    assign par_xor = (^shift_q) ^ bit_val;
    assign frm_now = frm_flag_q | ~bit_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= 2'b11;
            div_cnt_q <= '0;
        end else begin
            sync_q    <= {sync_q[0], bus.rx};
            div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            vote_q     <= 2'b11;
            shift_q    <= '0;
            par_flag_q <= 1'b0;
            frm_flag_q <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            vote_q     <= vote_d;
            shift_q    <= shift_d;
            par_flag_q <= par_flag_d;
            frm_flag_q <= frm_flag_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        vote_d     = vote_q;
        shift_d    = shift_q;
        par_flag_d = par_flag_q;
        frm_flag_d = frm_flag_q;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        valid_d    = 1'b0;

        if (tick) begin
            vote_d   = {vote_q[0], rxs};
            os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);

            case (state_q)
                S_IDLE: begin
                    if (!rxs) state_d = S_START;
                end
                S_START: begin
                    if (os_cnt_q == OS_MID) begin
                        state_d    = rxs ? S_IDLE : S_DATA;
                        bit_cnt_d  = '0;
                        par_flag_d = 1'b0;
                        frm_flag_d = 1'b0;
                    end
                end
                S_DATA: begin
                    if (os_cnt_q == OS_LAST) begin
                        shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (os_cnt_q == OS_LAST) begin
                        par_flag_d = (PARITY == 1) ? ~par_xor : par_xor;
                        state_d    = S_STOP;
                    end
                end
                S_STOP: begin
                    if (os_cnt_q == OS_LAST) begin
                        frm_flag_d = frm_now;
                        if (bit_cnt_q == LAST_STOP) begin
                            data_d  = shift_q;
                            perr_d  = par_flag_q;
                            ferr_d  = frm_now;
                            valid_d = 1'b1;
                            state_d = frm_now ? S_BREAK : S_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_BREAK: begin
                    if (rxs) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            if (state_d != state_q) os_cnt_d = '0;
        end
    end

    assign bus.data       = data_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: three receiver configurations (8N1, 8E1, 7N2)
// driven from a vector table, hand sequences and random frames.
module tb_uart_rx_core;
    localparam int DIV     = 4;
    localparam int OVS     = 16;
    localparam int BIT_CLK = DIV * OVS;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_rx_core_if #(.DATA_BITS(8)) if_a ();
    uart_rx_core_if #(.DATA_BITS(8)) if_p ();
    uart_rx_core_if #(.DATA_BITS(7)) if_s ();

    uart_rx_core #(.DIV(DIV), .OVERSAMPLE(OVS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    uart_rx_core #(.DIV(DIV), .OVERSAMPLE(OVS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        dut_p (.clk(clk), .reset(reset), .bus(if_p));
    uart_rx_core #(.DIV(DIV), .OVERSAMPLE(OVS), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
        dut_s (.clk(clk), .reset(reset), .bus(if_s));

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } rec_t;

    typedef struct {
        int         which;
        logic [8:0] word;
        logic       pbit;
        logic [1:0] stops;
        logic [8:0] e_data;
        logic       e_perr;
        logic       e_ferr;
    } vec_t;

    rec_t got_a[$];
    rec_t got_p[$];
    rec_t got_s[$];
    rec_t mon_a, mon_p, mon_s;

    int n_checks = 0;
    int n_fail   = 0;

    always @(negedge clk) begin
        if (if_a.valid === 1'b1) begin
            mon_a.data = 9'(if_a.data); mon_a.perr = if_a.parity_err; mon_a.ferr = if_a.frame_err;
            got_a.push_back(mon_a);
        end
        if (if_p.valid === 1'b1) begin
            mon_p.data = 9'(if_p.data); mon_p.perr = if_p.parity_err; mon_p.ferr = if_p.frame_err;
            got_p.push_back(mon_p);
        end
        if (if_s.valid === 1'b1) begin
            mon_s.data = 9'(if_s.data); mon_s.perr = if_s.parity_err; mon_s.ferr = if_s.frame_err;
            got_s.push_back(mon_s);
        end
    end

    function automatic int nb_of(int w);  return (w == 2) ? 7 : 8; endfunction
    function automatic int par_of(int w); return (w == 1) ? 2 : 0; endfunction
    function automatic int ns_of(int w);  return (w == 2) ? 2 : 1; endfunction

    function automatic int qsize(int w);
        case (w)
            0: return got_a.size();
            1: return got_p.size();
            default: return got_s.size();
        endcase
    endfunction

    function automatic logic busy_of(int w);
        case (w)
            0: return if_a.busy;
            1: return if_p.busy;
            default: return if_s.busy;
        endcase
    endfunction

    // {busy, valid, frame_err, parity_err, data}
    function automatic logic [12:0] outs_of(int w);
        case (w)
            0: return {if_a.busy, if_a.valid, if_a.frame_err, if_a.parity_err, 9'(if_a.data)};
            1: return {if_p.busy, if_p.valid, if_p.frame_err, if_p.parity_err, 9'(if_p.data)};
            default: return {if_s.busy, if_s.valid, if_s.frame_err, if_s.parity_err, 9'(if_s.data)};
        endcase
    endfunction

    // Expected outcome of a frame from the line-level rules alone.
    function automatic rec_t model(int w, logic [8:0] word, logic pbit, logic [1:0] stops);
        rec_t r;
        int   ones;
        r.data = word & 9'((1 << nb_of(w)) - 1);
        ones   = $countones(r.data) + int'(pbit);
        if (par_of(w) == 0)      r.perr = 1'b0;
        else if (par_of(w) == 2) r.perr = (ones % 2) != 0;
        else                     r.perr = (ones % 2) == 0;
        r.ferr = (stops[0] == 1'b0) || (ns_of(w) == 2 && stops[1] == 1'b0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_rx(input int w, input logic b);
        case (w)
            0: if_a.rx = b;
            1: if_p.rx = b;
            default: if_s.rx = b;
        endcase
    endtask

    task automatic hold(input int w, input logic b, input int n);
        set_rx(w, b);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int w, input logic [8:0] word, input logic pbit,
                              input logic [1:0] stops);
        hold(w, 1'b0, BIT_CLK);
        for (int i = 0; i < nb_of(w); i++) hold(w, word[i], BIT_CLK);
        if (par_of(w) != 0) hold(w, pbit, BIT_CLK);
        for (int i = 0; i < ns_of(w); i++) hold(w, stops[i], BIT_CLK);
    endtask

    task automatic pop_rec(input int w, output rec_t r, output logic ok);
        for (int c = 0; c < 4 * BIT_CLK && qsize(w) == 0; c++) @(negedge clk);
        ok = (qsize(w) != 0);
        r  = '{9'h0, 1'b0, 1'b0};
        if (ok) begin
            case (w)
                0: r = got_a.pop_front();
                1: r = got_p.pop_front();
                default: r = got_s.pop_front();
            endcase
        end
    endtask

    task automatic check_rec(input int w, input rec_t e, input string tag);
        rec_t  r;
        logic  ok;
        pop_rec(w, r, ok);
        chk({tag, " valid seen"}, 32'(ok), 32'd1);
        if (ok) begin
            chk({tag, " data"},       32'(r.data), 32'(e.data));
            chk({tag, " parity_err"}, 32'(r.perr), 32'(e.perr));
            chk({tag, " frame_err"},  32'(r.ferr), 32'(e.ferr));
        end
    endtask

    initial begin
        repeat (300000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 300000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        rec_t e;
        logic [8:0] w9;
        logic       pb;
        logic [1:0] st;

        vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{1, 9'h037, 1'b0, 2'b11, 9'h037, 1'b1, 1'b0};
        vecs[2] = '{1, 9'h037, 1'b1, 2'b11, 9'h037, 1'b0, 1'b0};
        vecs[3] = '{2, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0};
        vecs[4] = '{2, 9'h02A, 1'b0, 2'b11, 9'h02A, 1'b0, 1'b0};
        vecs[5] = '{1, 9'h000, 1'b1, 2'b11, 9'h000, 1'b1, 1'b0};
        vecs[6] = '{2, 9'h07F, 1'b0, 2'b01, 9'h07F, 1'b0, 1'b1};
        vecs[7] = '{0, 9'h05A, 1'b0, 2'b10, 9'h05A, 1'b0, 1'b1};

        reset = 1'b0;
        if_a.rx = 1'b1; if_p.rx = 1'b1; if_s.rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        for (int w = 0; w < 3; w++) chk($sformatf("reset outputs dut%0d", w), 32'(outs_of(w)), 32'd0);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].which, vecs[i].word, vecs[i].pbit, vecs[i].stops);
            set_rx(vecs[i].which, 1'b1);
            e = '{vecs[i].e_data, vecs[i].e_perr, vecs[i].e_ferr};
            check_rec(vecs[i].which, e, $sformatf("vec%0d", i));
            repeat (BIT_CLK) @(negedge clk);
            chk($sformatf("vec%0d busy after", i), 32'(busy_of(vecs[i].which)), 32'd0);
            chk($sformatf("vec%0d single valid", i), 32'(qsize(vecs[i].which)), 32'd0);
        end

        // Glitch shorter than half a bit is rejected
        hold(0, 1'b0, 16);
        chk("glitch busy during", 32'(busy_of(0)), 32'd1);
        hold(0, 1'b1, BIT_CLK);
        chk("glitch busy after", 32'(busy_of(0)), 32'd0);
        chk("glitch no valid", 32'(qsize(0)), 32'd0);

        // Back-to-back frames on the 7N2 receiver
        send_frame(2, 9'h055, 1'b0, 2'b11);
        send_frame(2, 9'h02A, 1'b0, 2'b11);
        set_rx(2, 1'b1);
        check_rec(2, '{9'h055, 1'b0, 1'b0}, "b2b first");
        check_rec(2, '{9'h02A, 1'b0, 1'b0}, "b2b second");

        // Framing error followed by a held-low break
        send_frame(0, 9'h0C3, 1'b0, 2'b00);
        check_rec(0, '{9'h0C3, 1'b0, 1'b1}, "break frame");
        hold(0, 1'b0, 5 * BIT_CLK);
        chk("break busy", 32'(busy_of(0)), 32'd1);
        chk("break no extra valid", 32'(qsize(0)), 32'd0);
        hold(0, 1'b1, BIT_CLK);
        chk("break released busy", 32'(busy_of(0)), 32'd0);
        send_frame(0, 9'h03C, 1'b0, 2'b11);
        check_rec(0, '{9'h03C, 1'b0, 1'b0}, "after break");
        hold(0, 1'b1, BIT_CLK);

        // Reset in the middle of data bit 3 of 0xFF
        hold(0, 1'b0, BIT_CLK);
        hold(0, 1'b1, 3 * BIT_CLK + BIT_CLK / 2);
        reset = 1'b0;
        hold(0, 1'b1, 8);
        chk("mid reset outputs", 32'(outs_of(0)), 32'd0);
        reset = 1'b1;
        hold(0, 1'b1, 10 * BIT_CLK);
        chk("mid reset no partial", 32'(qsize(0)), 32'd0);
        chk("mid reset busy", 32'(busy_of(0)), 32'd0);
        send_frame(0, 9'h081, 1'b0, 2'b11);
        check_rec(0, '{9'h081, 1'b0, 1'b0}, "after reset");
        hold(0, 1'b1, BIT_CLK);

        // Random frames against the reference model
        for (int n = 0; n < 24; n++) begin
            int w;
            w  = (n % 2 == 0) ? 1 : 0;
            w9 = 9'($urandom_range(0, 255));
            pb = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b11;
            e  = model(w, w9, pb, st);
            send_frame(w, w9, pb, st);
            set_rx(w, 1'b1);
            check_rec(w, e, $sformatf("rand%0d", n));
            if (e.ferr) repeat (BIT_CLK) @(negedge clk);
            else        repeat ($urandom_range(0, 8)) @(negedge clk);
        end
        repeat (BIT_CLK) @(negedge clk);
        chk("rand no leftover a", 32'(qsize(0)), 32'd0);
        chk("rand no leftover p", 32'(qsize(1)), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
